shake256_absorb_ctrl: RTL and testbench
=======================================

# shake256_absorb_ctrl

Absorb-phase controller for the SHAKE256 datapath. Accepts a message as a stream of 1088-bit rate chunks, drives the combinational `pad` block on the final chunk, and issues one or two padded rate blocks to the Keccak permutation core over a valid/ready handshake. It sits between the message source and the permutation core. It decides whether padding fits in the current block or spills into an extra block.

## Interface

- RATE, 1088, rate in bits; fixed for SHAKE256
- PAD_MIN, 6, minimum free bits needed for suffix plus pad10*1; padding fits iff len <= RATE-PAD_MIN (1082)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- msg_valid  in  1  chunk present
- msg_ready  out  1  chunk accepted when msg_valid & msg_ready
- msg_data  in  1088  chunk bits, MSB-first, valid bits left-justified
- msg_len  in  11  valid bits in chunk, 0..1088
- msg_last  in  1  final chunk of message
- pad_data_in  out  1088  to pad.data_in
- pad_len  out  11  to pad.data_length
- pad_out  in  1088  from pad.data_out
- pad_next  in  1088  from pad.data_next
- blk_valid  out  1  rate block available to core
- blk_ready  in  1  core accepts block
- blk_data  out  1088  registered block
- blk_first  out  1  block is first of message; core clears state
- blk_last  out  1  block is last absorb block; core enters squeeze after it
- msg_done  out  1  one-cycle pulse after final block handshake
- err  out  1  sticky protocol error

## Operation

- States: IDLE, SEND, SEND2.
- IDLE: msg_ready=1, blk_valid=0. pad_data_in=msg_data, pad_len=msg_len. In all other states both are driven to 0.
- On accept in IDLE, the controller loads blk_data and moves to SEND. The load depends on the chunk:
  - !msg_last: load msg_data, blk_last=0, no follow-up. If msg_len!=1088, set err and still treat the chunk as a full block.
  - msg_last & len<=1082: load pad_out, blk_last=1, no follow-up.
  - msg_last & 1083<=len<=1087: load pad_out, capture pad_next into next_reg, follow-up=NEXT, blk_last=0.
  - msg_last & len==1088: load msg_data unpadded, follow-up=ZPAD, blk_last=0.
  - len>1088: set err and truncate to 1088 (treated as the len==1088 case).
- SEND: blk_valid=1, held stable until blk_ready. On handshake the next state depends on the follow-up:
  - none: go to IDLE.
  - NEXT: load blk_data from next_reg, blk_last=1, go to SEND2.
  - ZPAD: load blk_data from pad_out, which pad computes from data_in=0 and len=0; blk_last=1, go to SEND2.
- SEND2: blk_valid=1 until blk_ready, then go to IDLE.
- first_pend flag:
  - Set at reset.
  - Cleared on any block handshake.
  - Set again on the handshake of a blk_last=1 block.
  - blk_first=first_pend & blk_valid.
- msg_done is asserted in the cycle after the blk_last=1 handshake.
- A zero-length last chunk (len=0) is legal, including an empty message; it yields a single padded block.
- err is cleared only by reset. It never blocks flow.

## Timing

- Reset values:
  - state=IDLE, so msg_ready=1.
  - blk_valid=0, blk_data=0, blk_first=0, blk_last=0.
  - msg_done=0, err=0, first_pend=1.
  - pad_data_in and pad_len follow msg inputs.
- Latency: chunk accepted on edge N produces blk_valid=1 from cycle N+1. A spill block appears the cycle after the first block's handshake.
- Throughput is at most one chunk per 2 cycles. msg_ready=0 in SEND and SEND2, so input is never accepted while a block is pending.
- blk_data, blk_last and blk_first are stable while blk_valid & !blk_ready. blk_valid never drops without a handshake.
- The pad path is combinational. pad_out and pad_next are sampled in the same cycle the controller drives the pad inputs.
- rst_n low mid-operation immediately returns all outputs to reset values; the pending block and spill are discarded.
- msg_done is high for exactly one cycle and coincides with state=IDLE.

## Test plan

- Single chunk, last, len=30, blk_ready=1 -> one block equal to pad(data,30), blk_first=1 and blk_last=1 at cycle N+1; msg_done in the next cycle; msg_ready back to 1.
- Two full chunks then last len=5 -> three blocks. Only the first has blk_first=1; only the third has blk_last=1 and equals pad(data,5).
- Last chunk len=1087 -> block1=pad_out with blk_last=0, then block2=pad_next with blk_last=1; msg_ready=0 throughout until block2 is accepted.
- Last chunk len=1088 -> block1=msg_data unpadded, block2=pad(0,0) with blk_last=1. Len=1082 must give one block; len=1083 must give two.
- Hold blk_ready=0 for 5 cycles with random msg_valid -> blk_data stable, no chunk accepted; non-last chunk with len=100 sets err, which stays 1 until reset.
- Assert rst_n=0 while in SEND2 -> blk_valid=0 immediately. After release, the next message's first block has blk_first=1, and an empty message (last, len=0) yields exactly one block.

Source files
------------

// File: rtl/shake256_absorb_ctrl_if.sv
// ============================================================================
// shake256_absorb_ctrl_if : message, pad and permutation-core bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface shake256_absorb_ctrl_if #(
  parameter int RATE  = 1088,
  parameter int LEN_W = 11
);
  logic              msg_valid;
  logic              msg_ready;
  logic [RATE-1:0]   msg_data;
  logic [LEN_W-1:0]  msg_len;
  logic              msg_last;
  logic [RATE-1:0]   pad_data_in;
  logic [LEN_W-1:0]  pad_len;
  logic [RATE-1:0]   pad_out;
  logic [RATE-1:0]   pad_next;
  logic              blk_valid;
  logic              blk_ready;
  logic [RATE-1:0]   blk_data;
  logic              blk_first;
  logic              blk_last;
  logic              msg_done;
  logic              err;

  // Environment side: message source, pad block and permutation core
  modport master (
    output msg_valid, msg_data, msg_len, msg_last, pad_out, pad_next, blk_ready,
    input  msg_ready, pad_data_in, pad_len, blk_valid, blk_data, blk_first,
           blk_last, msg_done, err
  );

  modport slave (
    input  msg_valid, msg_data, msg_len, msg_last, pad_out, pad_next, blk_ready,
    output msg_ready, pad_data_in, pad_len, blk_valid, blk_data, blk_first,
           blk_last, msg_done, err
  );
endinterface

`default_nettype wire

// File: rtl/shake256_absorb_ctrl.sv
// ============================================================================
// shake256_absorb_ctrl : SHAKE256 absorb controller, splits padding over 1-2 blocks
// Rev 1.0
// ============================================================================
`default_nettype none

module shake256_absorb_ctrl #(
  parameter int RATE    = 1088,
  parameter int PAD_MIN = 6
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  shake256_absorb_ctrl_if.slave  bus
);

  localparam logic [10:0] LEN_FULL = 11'(RATE);
  localparam logic [10:0] LEN_FIT  = 11'(RATE - PAD_MIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_SEND2 = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    F_NONE = 2'd0,
    F_NEXT = 2'd1,
    F_ZPAD = 2'd2
  } follow_e;

  state_e          state_q,      state_d;
  follow_e         follow_q,     follow_d;
  logic [RATE-1:0] blk_data_q,   blk_data_d;
  logic [RATE-1:0] next_q,       next_d;
  logic            blk_last_q,   blk_last_d;
  logic            first_pend_q, first_pend_d;
  logic            done_q,       done_d;
  logic            err_q,        err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      follow_q     <= F_NONE;
      blk_data_q   <= '0;
      next_q       <= '0;
      blk_last_q   <= 1'b0;
      first_pend_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      follow_q     <= follow_d;
      blk_data_q   <= blk_data_d;
      next_q       <= next_d;
      blk_last_q   <= blk_last_d;
      first_pend_q <= first_pend_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    follow_d        = follow_q;
    blk_data_d      = blk_data_q;
    next_d          = next_q;
    blk_last_d      = blk_last_q;
    first_pend_d    = first_pend_q;
    done_d          = 1'b0;
    err_d           = err_q;
    bus.msg_ready   = 1'b0;
    bus.pad_data_in = '0;
    bus.pad_len     = '0;

    case (state_q)
      S_IDLE: begin
        bus.msg_ready   = 1'b1;
        bus.pad_data_in = bus.msg_data;
        bus.pad_len     = bus.msg_len;
        if (bus.msg_valid) begin
          state_d    = S_SEND;
          follow_d   = F_NONE;
          blk_last_d = 1'b0;
          if (!bus.msg_last) begin
            blk_data_d = bus.msg_data;
            if (bus.msg_len != LEN_FULL) begin
              err_d = 1'b1;
            end
          end else if (bus.msg_len >= LEN_FULL) begin
            // Full final chunk: no room for padding, so a pad(0,0) block follows
            blk_data_d = bus.msg_data;
            follow_d   = F_ZPAD;
            if (bus.msg_len != LEN_FULL) begin
              err_d = 1'b1;
            end
          end else if (bus.msg_len <= LEN_FIT) begin
            blk_data_d = bus.pad_out;
            blk_last_d = 1'b1;
          end else begin
            blk_data_d = bus.pad_out;
            next_d     = bus.pad_next;
            follow_d   = F_NEXT;
          end
        end
      end

      S_SEND: begin
        if (bus.blk_ready) begin
          first_pend_d = blk_last_q;
          case (follow_q)
            F_NEXT: begin
              blk_data_d = next_q;
              blk_last_d = 1'b1;
              state_d    = S_SEND2;
            end
            F_ZPAD: begin
              // pad inputs are forced to zero outside IDLE, so pad_out is pad(0,0)
              blk_data_d = bus.pad_out;
              blk_last_d = 1'b1;
              state_d    = S_SEND2;
            end
            default: begin
              done_d  = blk_last_q;
              state_d = S_IDLE;
            end
          endcase
        end
      end

      S_SEND2: begin
        if (bus.blk_ready) begin
          first_pend_d = 1'b1;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.blk_valid = (state_q != S_IDLE);
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.blk_first = first_pend_q & (state_q != S_IDLE);
  assign bus.msg_done  = done_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_shake256_absorb_ctrl.sv
// ============================================================================
// tb_shake256_absorb_ctrl : randomized bench with a block-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shake256_absorb_ctrl;

  localparam int W = 1088;

  typedef struct packed {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } blk_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  shake256_absorb_ctrl_if #(.RATE(W), .LEN_W(11)) ifc ();

  shake256_absorb_ctrl #(.RATE(W), .PAD_MIN(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  int   mode     = 0;
  int   done_cnt = 0;
  bit   err_exp  = 1'b0;
  blk_t obs_q[$];
  blk_t exp_q[$];
  logic held_v    = 1'b0;
  blk_t held;
  logic prev_done = 1'b0;

  // Message bits followed by suffix 1111, then pad10*1 closing the last rate block
  function automatic logic [2*W-1:0] pad2(input logic [W-1:0] d, input int len);
    logic [2*W-1:0] r;
    int L;
    int end_pos;
    r = '0;
    L = (len > W) ? W : len;
    for (int p = 0; p < L; p++) r[2*W-1-p] = d[W-1-p];
    for (int k = 0; k < 5; k++) r[2*W-1-L-k] = 1'b1;
    end_pos = (L + 6 <= W) ? W - 1 : 2*W - 1;
    r[2*W-1-end_pos] = 1'b1;
    return r;
  endfunction

  logic [2*W-1:0] w_pad;
  assign w_pad       = pad2(ifc.pad_data_in, int'(ifc.pad_len));
  assign ifc.pad_out  = w_pad[2*W-1:W];
  assign ifc.pad_next = w_pad[W-1:0];

  always @(posedge clk) begin
    #2;
    case (mode)
      0:       ifc.blk_ready = 1'b1;
      1:       ifc.blk_ready = 1'($urandom_range(0, 1));
      default: ifc.blk_ready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    logic [W-1:0] x;
    int hb;
    int w;
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      x  = obs ^ exp;
      hb = 0;
      for (int i = 0; i < W; i++) if (x[i] === 1'b1) hb = i;
      w = hb / 64;
      $display("FAIL %s: got %h want %h (64-bit word %0d)", tag,
               obs[w*64 +: 64], exp[w*64 +: 64], w);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v    = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (held_v) begin
        check("valid_hold", W'(ifc.blk_valid), W'(1'b1));
        check("data_hold",  ifc.blk_data,      held.d);
        check("first_hold", W'(ifc.blk_first), W'(held.f));
        check("last_hold",  W'(ifc.blk_last),  W'(held.l));
      end
      held_v = ifc.blk_valid && !ifc.blk_ready;
      held   = '{d: ifc.blk_data, f: ifc.blk_first, l: ifc.blk_last};
      if (ifc.blk_valid) begin
        check("rdy_busy", W'(ifc.msg_ready), W'(1'b0));
        if (ifc.blk_ready) obs_q.push_back('{d: ifc.blk_data, f: ifc.blk_first, l: ifc.blk_last});
      end
      if (ifc.msg_done) begin
        done_cnt++;
        check("done_idle", W'(ifc.msg_ready), W'(1'b1));
        check("done_once", W'(prev_done),     W'(1'b0));
      end
      prev_done = ifc.msg_done;
    end
  end

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_chunk(input logic [W-1:0] d, input int len, input bit last);
    int n;
    @(negedge clk);
    ifc.msg_data  = d;
    ifc.msg_len   = 11'(len);
    ifc.msg_last  = last;
    ifc.msg_valid = 1'b1;
    n = 0;
    while (!ifc.msg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.msg_ready) begin
      check("accept_timeout", W'(ifc.msg_ready), W'(1'b1));
      ifc.msg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ifc.msg_valid = 1'b0;
  endtask

  task automatic wait_done(input int c0);
    int n;
    n = 0;
    while (done_cnt == c0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", W'(done_cnt != c0), W'(1'b1));
  endtask

  task automatic compare_blocks();
    check("nblk", W'(obs_q.size()), W'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("blk_data",  obs_q[i].d,     exp_q[i].d);
      check("blk_first", W'(obs_q[i].f), W'(exp_q[i].f));
      check("blk_last",  W'(obs_q[i].l), W'(exp_q[i].l));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_message(input int nfull, input int full_len, input int last_len);
    logic [W-1:0]   d;
    logic [2*W-1:0] p;
    int c0;
    int L;
    c0 = done_cnt;
    for (int i = 0; i < nfull; i++) begin
      d = rand_vec();
      exp_q.push_back('{d: d, f: (i == 0), l: 1'b0});
      if (full_len != W) err_exp = 1'b1;
      send_chunk(d, full_len, 1'b0);
    end
    d = rand_vec();
    L = (last_len > W) ? W : last_len;
    if (last_len > W) err_exp = 1'b1;
    p = pad2(d, L);
    if (L + 6 <= W) begin
      exp_q.push_back('{d: p[2*W-1:W], f: (nfull == 0), l: 1'b1});
    end else begin
      exp_q.push_back('{d: p[2*W-1:W], f: (nfull == 0), l: 1'b0});
      exp_q.push_back('{d: p[W-1:0],   f: 1'b0,         l: 1'b1});
    end
    send_chunk(d, last_len, 1'b1);
    wait_done(c0);
    compare_blocks();
    check("err", W'(ifc.err), W'(err_exp));
  endtask

  initial begin
    logic [W-1:0]   d;
    logic [2*W-1:0] p;
    int c0;
    int lens[10];
    lens = '{0, 1, 30, 1081, 1082, 1083, 1086, 1087, 1088, 500};

    ifc.msg_valid = 1'b0;
    ifc.msg_data  = rand_vec();
    ifc.msg_len   = 11'd77;
    ifc.msg_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  W'(ifc.msg_ready), W'(1'b1));
    check("rst_valid",  W'(ifc.blk_valid), W'(1'b0));
    check("rst_data",   ifc.blk_data,      '0);
    check("rst_first",  W'(ifc.blk_first), W'(1'b0));
    check("rst_last",   W'(ifc.blk_last),  W'(1'b0));
    check("rst_done",   W'(ifc.msg_done),  W'(1'b0));
    check("rst_err",    W'(ifc.err),       W'(1'b0));
    check("rst_padlen", W'(ifc.pad_len),   W'(11'd77));
    check("rst_padin",  ifc.pad_data_in,   ifc.msg_data);
    rst_n = 1'b1;
    @(negedge clk);

    // Single padded block with exact cycle timing
    mode = 0;
    d  = rand_vec();
    p  = pad2(d, 30);
    c0 = done_cnt;
    send_chunk(d, 30, 1'b1);
    check("lat_valid", W'(ifc.blk_valid), W'(1'b1));
    check("lat_data",  ifc.blk_data,      p[2*W-1:W]);
    check("lat_first", W'(ifc.blk_first), W'(1'b1));
    check("lat_last",  W'(ifc.blk_last),  W'(1'b1));
    check("lat_rdy",   W'(ifc.msg_ready), W'(1'b0));
    @(posedge clk); #1;
    check("lat_done",  W'(ifc.msg_done),  W'(1'b1));
    check("lat_rdy2",  W'(ifc.msg_ready), W'(1'b1));
    check("lat_idle",  W'(ifc.blk_valid), W'(1'b0));
    @(posedge clk); #1;
    check("lat_done0", W'(ifc.msg_done),  W'(1'b0));
    check("lat_nblk",  W'(obs_q.size()),  W'(1));
    check("lat_cnt",   W'(done_cnt - c0), W'(1));
    obs_q.delete();

    mode = 1;
    run_message(2, W, 5);
    run_message(0, W, 1087);
    run_message(0, W, 1088);
    run_message(0, W, 1082);
    run_message(0, W, 1083);
    for (int k = 0; k < 10; k++) begin
      run_message($urandom_range(0, 2), W,
                  (k == 9) ? int'($urandom_range(0, W)) : lens[$urandom_range(0, 9)]);
    end

    // Stall the core for 5 cycles while the source toggles msg_valid
    mode = 2;
    fork
      run_message(0, W, 1087);
      begin
        int n;
        n = 0;
        while (!ifc.blk_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (5) begin
          @(negedge clk);
          ifc.msg_valid = 1'($urandom_range(0, 1));
          ifc.msg_last  = 1'($urandom_range(0, 1));
          ifc.msg_len   = 11'($urandom_range(0, W));
        end
        @(negedge clk);
        ifc.msg_valid = 1'b0;
        mode = 1;
      end
    join

    run_message(1, 100, 20);
    run_message(1, W, 1500);
    run_message(0, W, 1084);

    // Reset while the spill block is pending
    mode = 2;
    send_chunk(rand_vec(), 1087, 1'b1);
    mode = 0;
    @(posedge clk); #1;
    mode = 2;
    check("s2_valid", W'(ifc.blk_valid), W'(1'b1));
    check("s2_last",  W'(ifc.blk_last),  W'(1'b1));
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", W'(ifc.blk_valid), W'(1'b0));
    check("ar_ready", W'(ifc.msg_ready), W'(1'b1));
    check("ar_last",  W'(ifc.blk_last),  W'(1'b0));
    check("ar_data",  ifc.blk_data,      '0);
    check("ar_err",   W'(ifc.err),       W'(1'b0));
    obs_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1;
    run_message(0, W, 0);
    run_message(1, W, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
